// File: rtl/alu_wide_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_wide_sequencer_if / alu_wide_sequencer_alu_if
// Purpose  : Bundles for the 64-bit ALU sequencer.
//            alu_wide_sequencer_if     - request/response channel.
//                master = execute-stage control, slave = sequencer.
//            alu_wide_sequencer_alu_if - link to the 32-bit combinational ALU.
//                master = sequencer, slave = ALU.
// Revision : 1.0 - initial release
// ============================================================================

interface alu_wide_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        req_cin;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_result;
    logic        rsp_wr;
    logic        rsp_n;
    logic        rsp_z;
    logic        rsp_c;
    logic        rsp_v;

    modport master (
        output req_valid, req_op, req_a, req_b, req_cin, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_wr, rsp_n, rsp_z, rsp_c, rsp_v
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_cin, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_wr, rsp_n, rsp_z, rsp_c, rsp_v
    );
endinterface

interface alu_wide_sequencer_alu_if;
    logic [31:0] alu_il;
    logic [31:0] alu_ir;
    logic [3:0]  alu_if;
    logic        alu_cin;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic        alu_n;
    logic        alu_cout;
    logic        alu_v;

    modport master (
        output alu_il, alu_ir, alu_if, alu_cin,
        input  alu_out, alu_zero, alu_n, alu_cout, alu_v
    );

    modport slave (
        input  alu_il, alu_ir, alu_if, alu_cin,
        output alu_out, alu_zero, alu_n, alu_cout, alu_v
    );
endinterface

`default_nettype wire

// File: rtl/alu_wide_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_wide_sequencer
// Purpose  : Runs a 64-bit ARM data-processing operation on a single 32-bit
//            combinational ALU as two passes: low word, then high word with
//            the low-pass carry chained in.
// Ports    : clk      - system clock, rising edge
//            rst_n    - asynchronous reset, active-low
//            req_bus  - request/response handshake channel (slave side)
//            alu_bus  - ALU operands/function/carry out, result/flags in
//                       (master side)
// Revision : 1.0 - initial release
// ============================================================================

module alu_wide_sequencer (
    input wire                        clk,
    input wire                        rst_n,
    alu_wide_sequencer_if.slave       req_bus,
    alu_wide_sequencer_alu_if.master  alu_bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [3:0] C_OP_SUB = 4'b0010;
    localparam logic [3:0] C_OP_RSB = 4'b0011;
    localparam logic [3:0] C_OP_ADD = 4'b0100;
    localparam logic [3:0] C_OP_ADC = 4'b0101;
    localparam logic [3:0] C_OP_SBC = 4'b0110;
    localparam logic [3:0] C_OP_RSC = 4'b0111;
    localparam logic [3:0] C_OP_CMP = 4'b1010;
    localparam logic [3:0] C_OP_CMN = 4'b1011;

    state_t      state_q, state_d;
    logic [31:0] a_hi_q, a_hi_d;
    logic [31:0] b_hi_q, b_hi_d;
    logic [3:0]  op_q, op_d;
    logic        cin_q, cin_d;
    logic [31:0] lo_res_q, lo_res_d;
    logic        lo_z_q, lo_z_d;
    logic [31:0] alu_il_q, alu_il_d;
    logic [31:0] alu_ir_q, alu_ir_d;
    logic [3:0]  alu_if_q, alu_if_d;
    logic        alu_cin_q, alu_cin_d;
    logic [63:0] rsp_result_q, rsp_result_d;
    logic        rsp_wr_q, rsp_wr_d;
    logic        rsp_n_q, rsp_n_d;
    logic        rsp_z_q, rsp_z_d;
    logic        rsp_c_q, rsp_c_d;
    logic        rsp_v_q, rsp_v_d;

    logic [3:0]  hi_op;
    logic        op_is_arith;

    // High pass turns every arithmetic op into its carry-consuming form so
    // the low-pass carry (C = NOT borrow for subtracts) completes the chain.
    always_comb begin
        hi_op       = op_q;
        op_is_arith = 1'b0;
        case (op_q)
            C_OP_ADD, C_OP_ADC, C_OP_CMN: begin
                hi_op       = C_OP_ADC;
                op_is_arith = 1'b1;
            end
            C_OP_SUB, C_OP_SBC, C_OP_CMP: begin
                hi_op       = C_OP_SBC;
                op_is_arith = 1'b1;
            end
            C_OP_RSB, C_OP_RSC: begin
                hi_op       = C_OP_RSC;
                op_is_arith = 1'b1;
            end
            default: begin
                hi_op       = op_q;
                op_is_arith = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        a_hi_d       = a_hi_q;
        b_hi_d       = b_hi_q;
        op_d         = op_q;
        cin_d        = cin_q;
        lo_res_d     = lo_res_q;
        lo_z_d       = lo_z_q;
        alu_il_d     = alu_il_q;
        alu_ir_d     = alu_ir_q;
        alu_if_d     = alu_if_q;
        alu_cin_d    = alu_cin_q;
        rsp_result_d = rsp_result_q;
        rsp_wr_d     = rsp_wr_q;
        rsp_n_d      = rsp_n_q;
        rsp_z_d      = rsp_z_q;
        rsp_c_d      = rsp_c_q;
        rsp_v_d      = rsp_v_q;

        case (state_q)
            ST_IDLE: begin
                if (req_bus.req_valid) begin
                    state_d   = ST_LO;
                    // Only the high halves are needed after the low pass
                    // has been launched.
                    a_hi_d    = req_bus.req_a[63:32];
                    b_hi_d    = req_bus.req_b[63:32];
                    op_d      = req_bus.req_op;
                    cin_d     = req_bus.req_cin;
                    alu_il_d  = req_bus.req_a[31:0];
                    alu_ir_d  = req_bus.req_b[31:0];
                    alu_if_d  = req_bus.req_op;
                    alu_cin_d = req_bus.req_cin;
                end
            end
            ST_LO: begin
                state_d   = ST_HI;
                lo_res_d  = alu_bus.alu_out;
                lo_z_d    = alu_bus.alu_zero;
                alu_il_d  = a_hi_q;
                alu_ir_d  = b_hi_q;
                alu_if_d  = hi_op;
                alu_cin_d = op_is_arith ? alu_bus.alu_cout : cin_q;
            end
            ST_HI: begin
                state_d      = ST_RESP;
                rsp_result_d = {alu_bus.alu_out, lo_res_q};
                rsp_n_d      = alu_bus.alu_n;
                rsp_c_d      = alu_bus.alu_cout;
                rsp_v_d      = alu_bus.alu_v;
                rsp_z_d      = lo_z_q & alu_bus.alu_zero;
                // TST/TEQ/CMP/CMN only update flags.
                rsp_wr_d     = ~(op_q[3:2] == 2'b10);
            end
            ST_RESP: begin
                if (req_bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            a_hi_q       <= 32'd0;
            b_hi_q       <= 32'd0;
            op_q         <= 4'd0;
            cin_q        <= 1'b0;
            lo_res_q     <= 32'd0;
            lo_z_q       <= 1'b0;
            alu_il_q     <= 32'd0;
            alu_ir_q     <= 32'd0;
            alu_if_q     <= 4'd0;
            alu_cin_q    <= 1'b0;
            rsp_result_q <= 64'd0;
            rsp_wr_q     <= 1'b0;
            rsp_n_q      <= 1'b0;
            rsp_z_q      <= 1'b0;
            rsp_c_q      <= 1'b0;
            rsp_v_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_hi_q       <= a_hi_d;
            b_hi_q       <= b_hi_d;
            op_q         <= op_d;
            cin_q        <= cin_d;
            lo_res_q     <= lo_res_d;
            lo_z_q       <= lo_z_d;
            alu_il_q     <= alu_il_d;
            alu_ir_q     <= alu_ir_d;
            alu_if_q     <= alu_if_d;
            alu_cin_q    <= alu_cin_d;
            rsp_result_q <= rsp_result_d;
            rsp_wr_q     <= rsp_wr_d;
            rsp_n_q      <= rsp_n_d;
            rsp_z_q      <= rsp_z_d;
            rsp_c_q      <= rsp_c_d;
            rsp_v_q      <= rsp_v_d;
        end
    end

    assign req_bus.req_ready  = (state_q == ST_IDLE);
    assign req_bus.rsp_valid  = (state_q == ST_RESP);
    assign req_bus.rsp_result = rsp_result_q;
    assign req_bus.rsp_wr     = rsp_wr_q;
    assign req_bus.rsp_n      = rsp_n_q;
    assign req_bus.rsp_z      = rsp_z_q;
    assign req_bus.rsp_c      = rsp_c_q;
    assign req_bus.rsp_v      = rsp_v_q;

    assign alu_bus.alu_il     = alu_il_q;
    assign alu_bus.alu_ir     = alu_ir_q;
    assign alu_bus.alu_if     = alu_if_q;
    assign alu_bus.alu_cin    = alu_cin_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_wide_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_wide_sequencer
// Purpose  : Self-checking bench for alu_wide_sequencer. Provides a 32-bit
//            ARM ALU responder, a 64-bit behavioural reference, and a
//            per-cycle compare process.
// Revision : 1.0 - initial release
// ============================================================================

module tb_alu_wide_sequencer;

    typedef struct packed {
        logic [63:0] res;
        logic        wr;
        logic        n;
        logic        z;
        logic        c;
        logic        v;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_wide_sequencer_if     req_bus ();
    alu_wide_sequencer_alu_if alu_bus ();

    alu_wide_sequencer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_bus (req_bus),
        .alu_bus (alu_bus)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    // ---------------- 32-bit ARM ALU responder ----------------
    logic [31:0] t_x, t_y, t_r;
    logic        t_ci, t_ar;
    logic [32:0] t_s;
    always_comb begin
        t_x  = alu_bus.alu_il;
        t_y  = alu_bus.alu_ir;
        t_ci = 1'b0;
        t_ar = 1'b1;
        t_r  = 32'd0;
        case (alu_bus.alu_if)
            4'h0, 4'h8: begin t_ar = 1'b0; t_r = alu_bus.alu_il & alu_bus.alu_ir; end
            4'h1, 4'h9: begin t_ar = 1'b0; t_r = alu_bus.alu_il ^ alu_bus.alu_ir; end
            4'h2, 4'hA: begin t_y = ~alu_bus.alu_ir; t_ci = 1'b1; end
            4'h3:       begin t_x = ~alu_bus.alu_il; t_ci = 1'b1; end
            4'h4, 4'hB: begin t_ci = 1'b0; end
            4'h5:       begin t_ci = alu_bus.alu_cin; end
            4'h6:       begin t_y = ~alu_bus.alu_ir; t_ci = alu_bus.alu_cin; end
            4'h7:       begin t_x = ~alu_bus.alu_il; t_ci = alu_bus.alu_cin; end
            4'hC:       begin t_ar = 1'b0; t_r = alu_bus.alu_il | alu_bus.alu_ir; end
            4'hD:       begin t_ar = 1'b0; t_r = alu_bus.alu_ir; end
            4'hE:       begin t_ar = 1'b0; t_r = alu_bus.alu_il & ~alu_bus.alu_ir; end
            default:    begin t_ar = 1'b0; t_r = ~alu_bus.alu_ir; end
        endcase
        t_s = {1'b0, t_x} + {1'b0, t_y} + {32'd0, t_ci};
        if (t_ar) t_r = t_s[31:0];
        alu_bus.alu_out  = t_r;
        alu_bus.alu_zero = (t_r == 32'd0);
        alu_bus.alu_n    = t_r[31];
        alu_bus.alu_cout = t_ar ? t_s[32] : alu_bus.alu_cin;
        alu_bus.alu_v    = t_ar ? ((t_x[31] == t_y[31]) && (t_r[31] != t_x[31])) : 1'b0;
    end

    // ---------------- 64-bit behavioural reference ----------------
    function automatic logic is_arith(input logic [3:0] op);
        return (op >= 4'h2 && op <= 4'h7) || op == 4'hA || op == 4'hB;
    endfunction

    // Whole 64-bit operation as a single addition x + y + ci.
    function automatic void addends(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                    input logic cin, output logic [63:0] x, output logic [63:0] y,
                                    output logic ci);
        x = a; y = b; ci = 1'b0;
        case (op)
            4'h2, 4'hA: begin y = ~b; ci = 1'b1; end
            4'h3:       begin x = ~a; ci = 1'b1; end
            4'h5:       ci = cin;
            4'h6:       begin y = ~b; ci = cin; end
            4'h7:       begin x = ~a; ci = cin; end
            default:    ci = 1'b0;
        endcase
    endfunction

    function automatic rsp_t model64(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                     input logic cin);
        rsp_t r;
        logic [63:0] x, y;
        logic ci;
        logic [64:0] s;
        addends(op, a, b, cin, x, y, ci);
        s = {1'b0, x} + {1'b0, y} + {64'd0, ci};
        case (op)
            4'h0, 4'h8: r.res = a & b;
            4'h1, 4'h9: r.res = a ^ b;
            4'hC:       r.res = a | b;
            4'hD:       r.res = b;
            4'hE:       r.res = a & ~b;
            4'hF:       r.res = ~b;
            default:    r.res = s[63:0];
        endcase
        r.c  = is_arith(op) ? s[64] : cin;
        r.v  = is_arith(op) ? ((x[63] == y[63]) && (r.res[63] != x[63])) : 1'b0;
        r.n  = r.res[63];
        r.z  = (r.res == 64'd0);
        r.wr = !(op >= 4'h8 && op <= 4'hB);
        return r;
    endfunction

    function automatic logic low_carry(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                       input logic cin);
        logic [63:0] x, y;
        logic ci;
        logic [32:0] s;
        addends(op, a, b, cin, x, y, ci);
        s = {1'b0, x[31:0]} + {1'b0, y[31:0]} + {32'd0, ci};
        return s[32];
    endfunction

    function automatic logic [3:0] hi_op(input logic [3:0] op);
        case (op)
            4'h4, 4'h5, 4'hB: return 4'h5;
            4'h2, 4'h6, 4'hA: return 4'h6;
            4'h3, 4'h7:       return 4'h7;
            default:          return op;
        endcase
    endfunction

    // ---------------- transaction-timing model ----------------
    logic        m_busy, m_seen;
    int          m_cyc;
    logic [3:0]  m_op;
    logic [63:0] m_a, m_b;
    logic        m_cin;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_seen <= 1'b0;
            m_cyc  <= 0;
        end else if (!m_busy) begin
            if (req_bus.req_valid) begin
                m_busy <= 1'b1;
                m_seen <= 1'b1;
                m_cyc  <= 0;
                m_op   <= req_bus.req_op;
                m_a    <= req_bus.req_a;
                m_b    <= req_bus.req_b;
                m_cin  <= req_bus.req_cin;
            end
        end else if (m_cyc < 2) begin
            m_cyc <= m_cyc + 1;
        end else if (req_bus.rsp_ready) begin
            m_busy <= 1'b0;
        end
    end

    // ---------------- per-cycle compare ----------------
    rsp_t e;
    always @(negedge clk) begin
        chk("req_ready", {63'd0, req_bus.req_ready}, {63'd0, !m_busy});
        chk("rsp_valid", {63'd0, req_bus.rsp_valid}, {63'd0, m_busy && m_cyc == 2});
        if (!m_seen) begin
            chk("alu_in_reset", {alu_bus.alu_il, alu_bus.alu_ir},
                64'd0);
            chk("alu_ctl_reset", {59'd0, alu_bus.alu_if, alu_bus.alu_cin}, 64'd0);
            chk("rsp_res_reset", req_bus.rsp_result, 64'd0);
            chk("rsp_flags_reset", {59'd0, req_bus.rsp_wr, req_bus.rsp_n, req_bus.rsp_z,
                                    req_bus.rsp_c, req_bus.rsp_v}, 64'd0);
        end else if (m_busy && m_cyc == 0) begin
            chk("alu_lo_ops", {alu_bus.alu_il, alu_bus.alu_ir}, {m_a[31:0], m_b[31:0]});
            chk("alu_lo_ctl", {59'd0, alu_bus.alu_if, alu_bus.alu_cin}, {59'd0, m_op, m_cin});
        end else begin
            chk("alu_hi_ops", {alu_bus.alu_il, alu_bus.alu_ir}, {m_a[63:32], m_b[63:32]});
            chk("alu_hi_ctl", {59'd0, alu_bus.alu_if, alu_bus.alu_cin},
                {59'd0, hi_op(m_op), is_arith(m_op) ? low_carry(m_op, m_a, m_b, m_cin) : m_cin});
        end
        if (m_busy && m_cyc == 2) begin
            e = model64(m_op, m_a, m_b, m_cin);
            chk("rsp_result", req_bus.rsp_result, e.res);
            chk("rsp_flags", {59'd0, req_bus.rsp_wr, req_bus.rsp_n, req_bus.rsp_z,
                              req_bus.rsp_c, req_bus.rsp_v},
                {59'd0, e.wr, e.n, e.z, e.c, e.v});
        end
    end

    // ---------------- driver tasks (start and end just after negedge) ----
    task automatic send(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic cin);
        int n = 0;
        req_bus.req_op    = op;
        req_bus.req_a     = a;
        req_bus.req_b     = b;
        req_bus.req_cin   = cin;
        req_bus.req_valid = 1'b1;
        while (!req_bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_bus.req_ready) begin
            chk("accept_timeout", 64'd0, 64'd1);
        end else begin
            @(posedge clk);
        end
        @(negedge clk);
        req_bus.req_valid = 1'b0;
    endtask

    task automatic get_rsp(input int max_stall, output rsp_t got);
        int n = 0;
        got = '0;
        while (!req_bus.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_bus.rsp_valid) begin
            chk("rsp_timeout", 64'd0, 64'd1);
            return;
        end
        repeat ($urandom_range(0, max_stall)) @(negedge clk);
        got = {req_bus.rsp_result, req_bus.rsp_wr, req_bus.rsp_n, req_bus.rsp_z,
               req_bus.rsp_c, req_bus.rsp_v};
        req_bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_bus.rsp_ready = 1'b0;
    endtask

    task automatic directed(input string name, input logic [3:0] op, input logic [63:0] a,
                            input logic [63:0] b, input logic [3:0] exp_hi_if,
                            input logic exp_hi_cin, input rsp_t exp);
        rsp_t got;
        send(op, a, b, 1'b0);
        chk({name, "_lo_if"}, {60'd0, alu_bus.alu_if}, {60'd0, op});
        @(negedge clk);
        chk({name, "_hi_if"}, {60'd0, alu_bus.alu_if}, {60'd0, exp_hi_if});
        chk({name, "_hi_cin"}, {63'd0, alu_bus.alu_cin}, {63'd0, exp_hi_cin});
        get_rsp(0, got);
        chk({name, "_res"}, got.res, exp.res);
        chk({name, "_flags"}, {59'd0, got.wr, got.n, got.z, got.c, got.v},
            {59'd0, exp.wr, exp.n, exp.z, exp.c, exp.v});
    endtask

    rsp_t pin;
    rsp_t got_g;
    logic [63:0] ra, rb;
    logic [3:0]  rop;

    initial begin
        rst_n             = 1'b0;
        req_bus.req_valid = 1'b0;
        req_bus.req_op    = 4'd0;
        req_bus.req_a     = 64'd0;
        req_bus.req_b     = 64'd0;
        req_bus.req_cin   = 1'b0;
        req_bus.rsp_ready = 1'b0;

        // Pin the reference model with hand-computed values.
        pin = model64(4'h4, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0);
        chk("pin_add", {pin.res, 3'd0, pin.wr, pin.n, pin.z, pin.c, pin.v},
            {64'h0000_0001_0000_0000, 8'b0001_0000});
        chk("pin_add_lc", {63'd0, low_carry(4'h4, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0)}, 64'd1);
        pin = model64(4'hA, 64'h8000_0000_0000_0000, 64'd1, 1'b0);
        chk("pin_cmp", {pin.res, 3'd0, pin.wr, pin.n, pin.z, pin.c, pin.v},
            {64'h7FFF_FFFF_FFFF_FFFF, 8'b0000_0011});
        pin = model64(4'h2, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0);
        chk("pin_sub_eq", {pin.res, 3'd0, pin.wr, pin.n, pin.z, pin.c, pin.v},
            {64'd0, 8'b0001_0110});

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        directed("add_chain", 4'h4, 64'h0000_0000_FFFF_FFFF, 64'd1, 4'h5, 1'b1,
                 {64'h0000_0001_0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        directed("sub_eq", 4'h2, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 4'h6, 1'b1,
                 {64'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
        directed("cmp_ovf", 4'hA, 64'h8000_0000_0000_0000, 64'd1, 4'h6, 1'b0,
                 {64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
        directed("and_z", 4'h0, 64'hFFFF_0000_0000_0000, 64'h0000_FFFF_FFFF_FFFF, 4'h0, 1'b0,
                 {64'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        directed("and_nz", 4'h0, 64'hFFFF_FFFF_0000_0001, 64'h0000_0000_0000_0001, 4'h0, 1'b0,
                 {64'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});

        // Backpressure with a second request pending.
        send(4'h5, 64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b1);
        while (!req_bus.rsp_valid) @(negedge clk);
        req_bus.req_op    = 4'h1;
        req_bus.req_a     = 64'hDEAD_BEEF_CAFE_F00D;
        req_bus.req_b     = 64'h0F0F_0F0F_F0F0_F0F0;
        req_bus.req_cin   = 1'b0;
        req_bus.req_valid = 1'b1;
        repeat (5) @(negedge clk);
        req_bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_bus.rsp_ready = 1'b0;
        chk("bp_ready_after_hs", {63'd0, req_bus.req_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        req_bus.req_valid = 1'b0;
        chk("bp_second_accept", {32'd0, alu_bus.alu_il}, 64'h0000_0000_CAFE_F00D);
        get_rsp(2, got_g);
        chk("bp_second_res", got_g.res, 64'hDEAD_BEEF_CAFE_F00D ^ 64'h0F0F_0F0F_F0F0_F0F0);

        // Reset in the high pass.
        send(4'h4, 64'h7777_8888_9999_AAAA, 64'h1111_2222_3333_4444, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", {63'd0, req_bus.rsp_valid}, 64'd0);
        chk("rst_req_ready", {63'd0, req_bus.req_ready}, 64'd1);
        chk("rst_alu", {alu_bus.alu_il, alu_bus.alu_ir}, 64'd0);
        chk("rst_alu_ctl", {59'd0, alu_bus.alu_if, alu_bus.alu_cin}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        directed("post_rst", 4'h6, 64'h0000_0001_0000_0000, 64'd1, 4'h6, 1'b0,
                 {64'h0000_0000_FFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});

        // Randomized operations.
        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: rb = ra;
                1: ra = 64'hFFFF_FFFF_FFFF_FFFF;
                2: rb = {32'd0, $urandom};
                3: ra = 64'h8000_0000_0000_0000;
                default: ;
            endcase
            send(rop, ra, rb, 1'($urandom_range(0, 1)));
            get_rsp(3, got_g);
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_wide_sequencer.md
# alu_wide_sequencer

Multi-cycle initiator that drives the 32-bit ARM data-processing ALU to execute 64-bit operations as two chained passes: low word, then high word with carry propagated. It sits between the execute-stage control and the combinational ALU. It owns the ALU operand, function and carry-in inputs, and samples the ALU result and flag outputs. Requests and responses use valid/ready handshakes, so long multiply-accumulate and 64-bit compare paths can reuse the single ALU.

## Interface
Parameters:
- none. Widths are fixed: 32-bit ALU, 64-bit request.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_op  in  4  ARM data-processing opcode (0000 AND … 1111 MVN)
- req_a  in  64  left operand
- req_b  in  64  right operand
- req_cin  in  1  incoming C flag
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_result  out  64  {high pass result, low pass result}
- rsp_wr  out  1  result is to be written; 0 for TST/TEQ/CMP/CMN (1000–1011)
- rsp_n, rsp_z, rsp_c, rsp_v  out  1 each  64-bit flags
- alu_il, alu_ir  out  32 each  ALU left/right operand
- alu_if  out  4  ALU function select
- alu_cin  out  1  ALU carry in
- alu_out  in  32  ALU result
- alu_zero, alu_n, alu_cout, alu_v  in  1 each  ALU flags

## Operation
- States: IDLE, LO, HI, RESP.
  - req_ready = 1 only in IDLE.
  - rsp_valid = 1 only in RESP.
- IDLE → LO on req_valid & req_ready:
  - Latch req_a, req_b, req_op, req_cin.
  - Register the ALU inputs: alu_il = a[31:0], alu_ir = b[31:0], alu_if = req_op, alu_cin = req_cin.
- LO → HI unconditionally:
  - Capture alu_out into lo_res and alu_zero into lo_z.
  - Load alu_il = a[63:32] and alu_ir = b[63:32].
  - Set alu_if by the high-pass mapping below.
- High-pass op mapping:
  - ADD→ADC, ADC→ADC, CMN→ADC.
  - SUB→SBC, SBC→SBC, CMP→SBC.
  - RSB→RSC, RSC→RSC.
  - All logical/move ops keep the same opcode.
- High-pass carry in:
  - Arithmetic ops: alu_cin = captured low-pass alu_cout (ARM C = NOT borrow, so the SUB/SBC chain is exact).
  - Logical ops: alu_cin = latched req_cin.
- HI → RESP unconditionally. Register the response:
  - rsp_result = {alu_out, lo_res}
  - rsp_n = alu_n, rsp_c = alu_cout, rsp_v = alu_v
  - rsp_z = lo_z & alu_zero
  - rsp_wr = ~(op[3:2] == 2'b10)
- RESP → IDLE on rsp_ready. All rsp_* outputs stay stable while rsp_valid & ~rsp_ready.
- The ALU is treated as purely combinational. Its outputs are sampled exactly one cycle after the sequencer registers its inputs.
- A new request is never accepted while in RESP, even when rsp_ready is high in the same cycle.

## Timing
- Reset (rst_n low, any state, immediate):
  - State → IDLE.
  - All registered outputs are 0: rsp_*, alu_il, alu_ir, alu_if, alu_cin.
  - req_ready = 1 while in IDLE.
  - In-flight operation is discarded; no response is produced.
- Latency:
  - Acceptance edge k.
  - Low pass sampled at k+1.
  - High pass sampled at k+2.
  - rsp_valid high after edge k+2.
- Throughput: at best one operation per 4 cycles (accept, LO, HI, RESP with rsp_ready=1).
- req_valid in a non-IDLE state is ignored. The requester must hold the request until req_ready.
- alu_* outputs hold the high-pass values through RESP and IDLE until the next acceptance.

## Test plan
- ADD carry chain:
  - Stimulus: a=0x0000_0000_FFFF_FFFF, b=1.
  - ALU side: alu_if 0100 then 0101, high alu_cin=1.
  - Response: result 0x0000_0001_0000_0000, N=0, Z=0, C=0, V=0, wr=1.
- SUB equal: a=b=0x1234_5678_9ABC_DEF0 → result 0, Z=1, C=1, V=0.
- CMP signed overflow:
  - Stimulus: a=0x8000_0000_0000_0000, b=1.
  - ALU side: high alu_if=0110 (SBC).
  - Response: V=1, N=0, C=1, wr=0.
- AND Z merge:
  - a=0xFFFF_0000_0000_0000, b=0x0000_FFFF_FFFF_FFFF → result 0, Z=1.
  - a=0xFFFF_FFFF_0000_0001, b=0x0000_0000_0000_0001 → Z=0.
- Backpressure:
  - Hold rsp_ready=0 for 5 cycles while a second req_valid is pending.
  - Required: rsp_* stable, req_ready=0 throughout.
  - Second request accepted exactly one edge after the rsp handshake.
- Reset mid-op: assert rst_n=0 in HI → no rsp_valid, outputs 0 immediately, next request completes normally.
